// File: rtl/rx_fifo_pkg.sv
// Shared types and entry layout for the receive frame-drop FIFO.
// The layout helpers take the widths as arguments so parameterised instances stay consistent.
package rx_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_KEEP_WIDTH = 8;
  localparam int DEF_DEPTH_LOG2 = 9;

  // One stored beat: {tlast, tkeep, tdata}.
  localparam int ENTRY_W   = DEF_DATA_WIDTH + DEF_KEEP_WIDTH + 1;
  localparam int TDATA_LSB = 0;
  localparam int TKEEP_LSB = DEF_DATA_WIDTH;
  localparam int TLAST_BIT = DEF_DATA_WIDTH + DEF_KEEP_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    DISCARD = 2'd2
  } wr_state_e;

  function automatic int entry_w(input int dw, input int kw);
    return dw + kw + 1;
  endfunction

  function automatic int tkeep_lsb(input int dw);
    return dw;
  endfunction

  function automatic int tlast_bit(input int dw, input int kw);
    return dw + kw;
  endfunction

endpackage

// File: rtl/rx_frame_ram.sv
// Simple dual-port frame storage: synchronous write, asynchronous (LUTRAM) read.
module rx_frame_ram
  import rx_fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_DEPTH_LOG2,
  parameter int DATA_W = ENTRY_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // NOTE: the array has no reset; entries are only read after being written,
  // and a reset would stop it mapping onto distributed RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rx_frame_drop_fifo.sv
// Store-and-forward buffer behind the 10G MAC RX stream: forwards only complete,
// error-free frames and drops bad or overflowing ones by rolling the write pointer back.
module rx_frame_drop_fifo
  import rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DEF_KEEP_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk156,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [31:0]           good_frames,
  output logic [31:0]           bad_frames,
  output logic [31:0]           overflow_frames,
  output logic                  drop_pulse
);

  localparam int EW    = entry_w(DATA_WIDTH, KEEP_WIDTH);
  localparam int K_LSB = tkeep_lsb(DATA_WIDTH);
  localparam int L_BIT = tlast_bit(DATA_WIDTH, KEEP_WIDTH);
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1) << DEPTH_LOG2;

  wr_state_e       r_state, w_state_nxt;
  logic [PW-1:0]   r_wr_ptr, r_wr_commit, r_rd_ptr;
  logic [PW-1:0]   w_wr_ptr_nxt, w_commit_nxt;
  logic            w_we, w_good_inc, w_bad_inc, w_ovf_inc;
  logic            w_full, w_avail, w_rd_en;
  logic [EW-1:0]   w_wr_entry, w_rd_entry;

  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep;
  logic                  r_tvalid, r_tlast, r_drop;
  logic [31:0]           r_good, r_bad, r_ovf;

  // Full check uses rd_ptr before this cycle's read, so it errs one beat early.
  assign w_full     = (r_wr_ptr - r_rd_ptr) == DEPTH;
  assign w_avail    = r_rd_ptr != r_wr_commit;
  assign w_rd_en    = w_avail && (!r_tvalid || m_axis_tready);
  assign w_wr_entry = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  rx_frame_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (EW)
  ) u_ram (
    .clk     (clk156),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rdata (w_rd_entry)
  );

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_we         = 1'b0;
    w_wr_ptr_nxt = r_wr_ptr;
    w_commit_nxt = r_wr_commit;
    w_good_inc   = 1'b0;
    w_bad_inc    = 1'b0;
    w_ovf_inc    = 1'b0;
    if (s_axis_tvalid) begin
      unique case (r_state)
        IDLE, WRITE: begin
          if (w_full) begin
            w_wr_ptr_nxt = r_wr_commit;
            if (s_axis_tlast) begin
              w_ovf_inc   = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = DISCARD;
            end
          end else begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + PW'(1);
            w_state_nxt  = s_axis_tlast ? IDLE : WRITE;
            if (s_axis_tlast && s_axis_tuser) begin
              w_wr_ptr_nxt = r_wr_commit;
              w_bad_inc    = 1'b1;
            end else if (s_axis_tlast) begin
              w_commit_nxt = r_wr_ptr + PW'(1);
              w_good_inc   = 1'b1;
            end
          end
        end
        DISCARD: begin
          // tuser is deliberately ignored here: the frame already counts as overflow.
          if (s_axis_tlast) begin
            w_ovf_inc   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk156) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      r_ovf       <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_wr_commit <= w_commit_nxt;
      r_drop      <= w_bad_inc | w_ovf_inc;
      if (w_good_inc) r_good <= r_good + 32'd1;
      if (w_bad_inc)  r_bad  <= r_bad + 32'd1;
      if (w_ovf_inc)  r_ovf  <= r_ovf + 32'd1;
    end
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tkeep  <= '0;
      r_tdata  <= '0;
    end else if (w_rd_en) begin
      r_rd_ptr <= r_rd_ptr + PW'(1);
      r_tvalid <= 1'b1;
      r_tlast  <= w_rd_entry[L_BIT];
      r_tkeep  <= w_rd_entry[K_LSB +: KEEP_WIDTH];
      r_tdata  <= w_rd_entry[0 +: DATA_WIDTH];
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata    = r_tdata;
  assign m_axis_tkeep    = r_tkeep;
  assign m_axis_tvalid   = r_tvalid;
  assign m_axis_tlast    = r_tlast;
  assign good_frames     = r_good;
  assign bad_frames      = r_bad;
  assign overflow_frames = r_ovf;
  assign drop_pulse      = r_drop;

endmodule

// File: tb/tb_rx_frame_drop_fifo.sv
// Directed bench for rx_frame_drop_fifo with a 16-beat buffer: good/bad/overflow
// frames, backpressure stability, pointer wrap and mid-frame reset.
module tb_rx_frame_drop_fifo;

  localparam int DW = 64;
  localparam int KW = 8;

  logic          clk156 = 1'b0;
  logic          reset;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0]   good_frames, bad_frames, overflow_frames;
  logic          drop_pulse;

  rx_frame_drop_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH_LOG2(4)) dut (
    .clk156          (clk156),
    .reset           (reset),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tuser    (s_axis_tuser),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .good_frames     (good_frames),
    .bad_frames      (bad_frames),
    .overflow_frames (overflow_frames),
    .drop_pulse      (drop_pulse)
  );

  always #5 clk156 = ~clk156;

  typedef logic [DW+KW:0] beat_t;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    bp_mode = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  beat_t obs_q[$];
  beat_t exp_q[$];
  int    obs_base = 0;
  int    dp_cnt = 0;
  int    stall_err = 0;

  // Output monitor: captures handshaken beats, counts drop pulses, checks stall stability.
  bit    prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b0;
  beat_t prev_beat = '0;
  always @(negedge clk156) begin
    if (m_axis_tvalid && m_axis_tready)
      obs_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
    if (drop_pulse) dp_cnt++;
    if (!prev_rst && prev_valid && !prev_ready &&
        !(m_axis_tvalid && ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} == prev_beat)))
      stall_err++;
    prev_valid = m_axis_tvalid;
    prev_ready = m_axis_tready;
    prev_rst   = reset;
    prev_beat  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk156);
    #1;
    cyc++;
    if (bp_mode) m_axis_tready = bp_pat[cyc % 4];
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [DW-1:0] mk_data(input int fid, input int b);
    return {16'hC0DE, 16'(fid), 32'(b)};
  endfunction

  // Drives one frame back-to-back; optionally records it as expected output.
  task automatic send_frame(input int fid, input int nbeats, input logic user, input bit expect_out);
    for (int b = 0; b < nbeats; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk_data(fid, b);
      s_axis_tkeep  = (b == nbeats - 1) ? 8'h3F : 8'hFF;
      s_axis_tlast  = (b == nbeats - 1);
      s_axis_tuser  = user && (b == nbeats - 1);
      if (expect_out) exp_q.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic check_output(input string tag);
    check({tag, "_count"}, 96'(obs_q.size() - obs_base), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_beat"}, 96'(obs_q[obs_base + i]), 96'(exp_q[i]));
    exp_q.delete();
    obs_base = obs_q.size();
  endtask

  task automatic check_counts(input string tag, input int g, input int b, input int o);
    check({tag, "_good"}, 96'(good_frames), 96'(g));
    check({tag, "_bad"},  96'(bad_frames), 96'(b));
    check({tag, "_ovf"},  96'(overflow_frames), 96'(o));
  endtask

  int dp_base;

  initial begin
    reset = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0;
    m_axis_tready = 1'b1;
    steps(3);
    check("rst_tvalid", 96'(m_axis_tvalid), 96'(0));
    check("rst_drop", 96'(drop_pulse), 96'(0));
    check_counts("rst", 0, 0, 0);
    reset = 1'b0;
    steps(2);

    // Good 8-beat frame; first output beat two edges after the input tlast.
    send_frame(1, 8, 1'b0, 1'b1);
    check("lat_t0_tvalid", 96'(m_axis_tvalid), 96'(0));
    step();
    check("lat_t1_tvalid", 96'(m_axis_tvalid), 96'(1));
    check("lat_t1_tdata", 96'(m_axis_tdata), 96'(mk_data(1, 0)));
    steps(12);
    check_output("good");
    check_counts("good", 1, 0, 0);

    // Bad 5-beat frame followed by a 3-beat good frame.
    dp_base = dp_cnt;
    send_frame(2, 5, 1'b1, 1'b0);
    send_frame(3, 3, 1'b0, 1'b1);
    steps(10);
    check_output("bad");
    check_counts("bad", 2, 1, 0);
    check("bad_drop_pulses", 96'(dp_cnt - dp_base), 96'(1));

    // Three back-to-back 4-beat frames under a 1,0,0,1 ready pattern.
    bp_mode = 1'b1;
    send_frame(4, 4, 1'b0, 1'b1);
    send_frame(5, 4, 1'b0, 1'b1);
    send_frame(6, 4, 1'b0, 1'b1);
    steps(40);
    bp_mode = 1'b0;
    m_axis_tready = 1'b1;
    steps(4);
    check_output("bp");
    check("bp_stall_stable", 96'(stall_err), 96'(0));
    check_counts("bp", 5, 1, 0);

    // Overflow: second 10-beat frame cannot fit behind the first while stalled.
    m_axis_tready = 1'b0;
    dp_base = dp_cnt;
    send_frame(7, 10, 1'b0, 1'b1);
    send_frame(8, 10, 1'b0, 1'b0);
    steps(3);
    check_counts("ovf", 6, 1, 1);
    check("ovf_drop_pulses", 96'(dp_cnt - dp_base), 96'(1));
    check("ovf_held_count", 96'(obs_q.size() - obs_base), 96'(0));
    m_axis_tready = 1'b1;
    steps(20);
    check_output("ovf");

    // 40 single-beat frames through a 16-entry buffer: pointers wrap twice.
    for (int f = 0; f < 40; f++) send_frame(100 + f, 1, 1'b0, 1'b1);
    steps(6);
    check_output("wrap");
    check_counts("wrap", 46, 1, 1);

    // Reset during beat 3 of a 6-beat frame with a committed 2-beat frame unread.
    m_axis_tready = 1'b0;
    send_frame(9, 2, 1'b0, 1'b0);
    steps(2);
    check("pre_rst_tvalid", 96'(m_axis_tvalid), 96'(1));
    for (int b = 0; b < 3; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk_data(10, b);
      s_axis_tkeep  = 8'hFF;
      s_axis_tlast  = 1'b0;
      reset         = (b == 2);
      step();
    end
    reset = 1'b0;
    s_axis_tvalid = 1'b0;
    check("mid_rst_tvalid", 96'(m_axis_tvalid), 96'(0));
    check_counts("mid_rst", 0, 0, 0);
    obs_base = obs_q.size();
    m_axis_tready = 1'b1;
    step();
    send_frame(11, 4, 1'b0, 1'b1);
    steps(8);
    check_output("post_rst");
    check_counts("post_rst", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
